offchip_memory_arbiter: RTL and testbench
=========================================

# offchip_memory_arbiter

Four-port round-robin arbiter between the per-memory-space marshallers (after address mapping) and the single off-chip memory interface. It serialises one full-line read or write transaction at a time onto the off-chip memory port. For reads, it returns the data to the requesting port with a one-cycle completion pulse.

## Interface
Parameters:
- W_OFF_A, 32, off-chip address width (bits).
- W_OFF_D, 512, off-chip data width (bits).
- NUM_PORTS, 4, requester count; fixed at 4 in this revision, ports numbered 0..3.

Ports:
- CLK  in  1  single clock.
- RST  in  1  reset, synchronous, active-high.
- ADDRn  in  W_OFF_A  request address, port n (n = 0..3).
- REn  in  1  read request, level, held until RDYn.
- WEn  in  1  write request, level, held until RDYn.
- Dn  in  W_OFF_D  write data, held stable with WEn.
- Qn  out  W_OFF_D  read data, valid while RDYn=1.
- RDYn  out  1  one-cycle completion pulse, port n.
- MEM_ADDR  out  W_OFF_A  off-chip address.
- MEM_RE  out  1  off-chip read request, level.
- MEM_WE  out  1  off-chip write request, level.
- MEM_D  out  W_OFF_D  off-chip write data.
- MEM_Q  in  W_OFF_D  off-chip read data, valid when MEM_RDY=1.
- MEM_RDY  in  1  off-chip completion pulse.

## Operation
- Request on port n = REn | WEn. If both are high, the arbiter performs a write and RDYn still pulses; Qn is don't-care in that case.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is present, grant the first requesting port searching from last_grant+1 (mod 4), wrapping.
  - Register addr, D and op (write wins), set last_grant, then go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - MEM_ADDR, MEM_D and MEM_RE/MEM_WE are driven from the registered copies; they are stable for the whole state.
  - On MEM_RDY=1: capture MEM_Q into the read-data register (reads only), deassert MEM_RE/MEM_WE from the next cycle, and go to RESP.
- RESP:
  - RDYn=1 for the granted port only, for exactly one cycle, then go to IDLE.
  - The requester drops REn/WEn in the cycle after RDYn.
  - The mandatory IDLE cycle that follows prevents re-granting a stale request.
- Read-data register:
  - Q0..Q3 are all driven from one shared read-data register.
  - It holds its value until the next read completion; RDYn is the only qualifier.
- MEM_RDY received in IDLE or RESP is ignored.
- Request changes on a non-granted port never affect the transaction in flight.
- last_grant resets to 3, so port 0 has first priority after reset.

## Timing
- Reset values:
  - state=IDLE, last_grant=3.
  - MEM_RE=0, MEM_WE=0, MEM_ADDR=0, MEM_D=0.
  - Q0..3=0, RDY0..3=0.
- All outputs are registered; no combinational path exists from any input to any output.
- Latency:
  - Request sampled in IDLE at edge k: MEM_RE/MEM_WE high from cycle k+1.
  - MEM_RDY sampled at edge m: MEM_RE/MEM_WE low and RDYn high in cycle m+1.
  - Arbiter becomes IDLE in cycle m+2.
  - Minimum transaction period per grant: 3 cycles + memory latency.
- Throughput: with all four ports continuously requesting, grants go 0,1,2,3,0,… and each port gets exactly one transaction per four grants.
- Reset asserted mid-transaction:
  - The next cycle shows reset values; the outstanding off-chip transaction is abandoned and no RDYn is issued.
  - A MEM_RDY arriving afterwards is ignored.

## Structure
- Shared package offchip_arbiter_pkg:
  - state enum {IDLE, BUSY, RESP};
  - NUM_PORTS=4;
  - port-index width localparam (2).
- Sub-module rr_picker:
  - purely combinational;
  - inputs: 4-bit request vector and last_grant;
  - outputs: grant_valid and 2-bit grant index.
  - It is reused by other arbiters in the memory system.

## Test plan
- Single read: RE0=1, ADDR0=0x100; memory returns MEM_RDY with MEM_Q=0xA5… after 5 cycles → MEM_RE high from cycle 1; RDY0 pulses once with Q0=0xA5…; RDY1..3 stay 0.
- Single write: WE2=1, ADDR2=0x40, D2=0xDEAD… → MEM_WE=1, MEM_ADDR=0x40, MEM_D=0xDEAD… held until MEM_RDY; RDY2 pulses once; MEM_RE stays 0 throughout.
- All four ports request simultaneously from reset, memory latency 2 → grant order 0,1,2,3, then 0 again if port 0 re-requests; no port is granted twice in a row while others wait.
- RE1 and WE1 both high → write issued (MEM_WE=1, MEM_RE=0); RDY1 pulses.
- RST asserted while in BUSY → next cycle MEM_RE=MEM_WE=0, all RDYn=0; a later MEM_RDY pulse produces no RDYn; the next request is served starting from port 0 priority.
- Spurious MEM_RDY in IDLE with no requests → no output changes; Q registers retain their prior value.

Source files
------------

// File: rtl/offchip_arbiter_pkg.sv
// Shared definitions for the off-chip memory arbiters: FSM state encoding and port sizing.
package offchip_arbiter_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int W_PORT_IDX = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/offchip_memory_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after the last grant, wrapping.
module rr_picker
  import offchip_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0]  i_req,
  input  logic [W_PORT_IDX-1:0] i_last_grant,
  output logic                  o_grant_valid,
  output logic [W_PORT_IDX-1:0] o_grant
);

  logic [W_PORT_IDX-1:0] w_idx;

  // Offsets 1..4 walk the ring so the last granted port has the lowest priority.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant       = i_last_grant;
    w_idx         = i_last_grant;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx = i_last_grant + W_PORT_IDX'(k);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant       = w_idx;
      end
    end
  end

endmodule

// File: rtl/offchip_memory_arbiter.sv
// Four-port round-robin arbiter serialising full-line reads/writes onto the off-chip memory port.
module offchip_memory_arbiter
  import offchip_arbiter_pkg::*;
#(
  parameter int W_OFF_A = 32,
  parameter int W_OFF_D = 512
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [W_OFF_A-1:0] i_addr0,
  input  logic [W_OFF_A-1:0] i_addr1,
  input  logic [W_OFF_A-1:0] i_addr2,
  input  logic [W_OFF_A-1:0] i_addr3,
  input  logic               i_re0,
  input  logic               i_re1,
  input  logic               i_re2,
  input  logic               i_re3,
  input  logic               i_we0,
  input  logic               i_we1,
  input  logic               i_we2,
  input  logic               i_we3,
  input  logic [W_OFF_D-1:0] i_d0,
  input  logic [W_OFF_D-1:0] i_d1,
  input  logic [W_OFF_D-1:0] i_d2,
  input  logic [W_OFF_D-1:0] i_d3,
  output logic [W_OFF_D-1:0] o_q0,
  output logic [W_OFF_D-1:0] o_q1,
  output logic [W_OFF_D-1:0] o_q2,
  output logic [W_OFF_D-1:0] o_q3,
  output logic               o_rdy0,
  output logic               o_rdy1,
  output logic               o_rdy2,
  output logic               o_rdy3,
  output logic [W_OFF_A-1:0] o_mem_addr,
  output logic               o_mem_re,
  output logic               o_mem_we,
  output logic [W_OFF_D-1:0] o_mem_d,
  input  logic [W_OFF_D-1:0] i_mem_q,
  input  logic               i_mem_rdy
);

  state_t                r_state;
  state_t                w_next_state;
  logic [W_PORT_IDX-1:0] r_last_grant;
  logic [NUM_PORTS-1:0]  r_rdy;
  logic [W_OFF_A-1:0]    r_mem_addr;
  logic [W_OFF_D-1:0]    r_mem_d;
  logic                  r_mem_re;
  logic                  r_mem_we;
  logic [W_OFF_D-1:0]    r_q;

  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_we;
  logic [W_OFF_A-1:0]    w_addr [NUM_PORTS];
  logic [W_OFF_D-1:0]    w_d    [NUM_PORTS];
  logic                  w_grant_valid;
  logic [W_PORT_IDX-1:0] w_grant;

  assign w_we    = {i_we3, i_we2, i_we1, i_we0};
  assign w_req   = {i_re3, i_re2, i_re1, i_re0} | w_we;
  assign w_addr[0] = i_addr0;
  assign w_addr[1] = i_addr1;
  assign w_addr[2] = i_addr2;
  assign w_addr[3] = i_addr3;
  assign w_d[0]    = i_d0;
  assign w_d[1]    = i_d1;
  assign w_d[2]    = i_d2;
  assign w_d[3]    = i_d3;

  rr_picker u_picker (
    .i_req         (w_req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = BUSY;
      BUSY:    if (i_mem_rdy) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // r_last_grant doubles as the in-flight port index while BUSY/RESP; a write wins when both ops are requested.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= W_PORT_IDX'(NUM_PORTS - 1);
      r_rdy        <= '0;
      r_mem_addr   <= '0;
      r_mem_d      <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_q          <= '0;
    end else begin
      r_rdy <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_last_grant <= w_grant;
            r_mem_addr   <= w_addr[w_grant];
            r_mem_d      <= w_d[w_grant];
            r_mem_we     <= w_we[w_grant];
            r_mem_re     <= ~w_we[w_grant];
          end
        end
        BUSY: begin
          if (i_mem_rdy) begin
            r_mem_re            <= 1'b0;
            r_mem_we            <= 1'b0;
            r_rdy[r_last_grant] <= 1'b1;
            if (r_mem_re) r_q <= i_mem_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_mem_d    = r_mem_d;
  assign o_mem_re   = r_mem_re;
  assign o_mem_we   = r_mem_we;
  assign o_rdy0     = r_rdy[0];
  assign o_rdy1     = r_rdy[1];
  assign o_rdy2     = r_rdy[2];
  assign o_rdy3     = r_rdy[3];
  assign o_q0       = r_q;
  assign o_q1       = r_q;
  assign o_q2       = r_q;
  assign o_q3       = r_q;

endmodule

// File: tb/tb_offchip_memory_arbiter.sv
// Directed self-checking bench for offchip_memory_arbiter: reads, writes, round-robin order, reset and spurious completions.
module tb_offchip_memory_arbiter;

  localparam int W_A = 32;
  localparam int W_D = 512;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W_A-1:0] addr [4];
  logic [3:0]     re = '0;
  logic [3:0]     we = '0;
  logic [W_D-1:0] d [4];
  logic [W_D-1:0] mem_q = '0;
  logic           mem_rdy = 1'b0;
  wire  [W_D-1:0] q0, q1, q2, q3;
  wire            rdy0, rdy1, rdy2, rdy3;
  wire  [W_A-1:0] mem_addr;
  wire            mem_re, mem_we;
  wire  [W_D-1:0] mem_d;
  wire  [3:0]     rdy = {rdy3, rdy2, rdy1, rdy0};

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [W_D-1:0] Q_A5 = {64{8'hA5}};
  localparam logic [W_D-1:0] D_DE = {16{32'hDEADBEEF}};
  localparam logic [W_D-1:0] D_12 = {16{32'h12345678}};
  localparam logic [W_D-1:0] Q_X  = {64{8'h5A}};
  localparam logic [W_D-1:0] Q_Y  = {64{8'h3C}};

  offchip_memory_arbiter #(.W_OFF_A(W_A), .W_OFF_D(W_D)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_addr2(addr[2]), .i_addr3(addr[3]),
    .i_re0(re[0]), .i_re1(re[1]), .i_re2(re[2]), .i_re3(re[3]),
    .i_we0(we[0]), .i_we1(we[1]), .i_we2(we[2]), .i_we3(we[3]),
    .i_d0(d[0]), .i_d1(d[1]), .i_d2(d[2]), .i_d3(d[3]),
    .o_q0(q0), .o_q1(q1), .o_q2(q2), .o_q3(q3),
    .o_rdy0(rdy0), .o_rdy1(rdy1), .o_rdy2(rdy2), .o_rdy3(rdy3),
    .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_d(mem_d),
    .i_mem_q(mem_q), .i_mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Bounded wait for the arbiter to raise an off-chip request; ok=0 when the budget expires.
  task automatic wait_mem_req(output bit ok);
    for (int i = 0; i < 12 && !(mem_re || mem_we); i++) @(negedge clk);
    ok = mem_re || mem_we;
  endtask

  task automatic pulse_mem_rdy(input logic [W_D-1:0] data);
    mem_q   = data;
    mem_rdy = 1'b1;
    @(negedge clk);
    mem_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_re, mem_we} !== 2'b00 || mem_addr !== '0 || mem_d !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mem: re=%b we=%b addr=%h, required 0 0 0", mem_re, mem_we, mem_addr);
    end
    n_checks++;
    if (rdy !== 4'b0000 || q0 !== '0 || q3 !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_rdy_q: rdy=%b q0[31:0]=%h, required 0000 0", rdy, q0[31:0]);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    addr[0] = 32'h100;
    re[0]   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL read_issue: re=%b we=%b addr=%h, required 1 0 00000100", mem_re, mem_we, mem_addr);
    end
    n_checks++;
    if (q0 !== '0) begin
      n_fail++;
      $display("[TB] FAIL read_q_before: q0[31:0]=%h, required 0", q0[31:0]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_re !== 1'b1 || mem_addr !== 32'h100 || rdy !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL read_hold: re=%b addr=%h rdy=%b, required 1 00000100 0000", mem_re, mem_addr, rdy);
      end
    end
    pulse_mem_rdy(Q_A5);
    n_checks++;
    if (rdy !== 4'b0001 || q0 !== Q_A5 || mem_re !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_done: rdy=%b q0[31:0]=%h re=%b, required 0001 a5a5a5a5 0", rdy, q0[31:0], mem_re);
    end
    re[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy !== 4'b0000 || mem_re !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_pulse_len: rdy=%b re=%b, required 0000 0", rdy, mem_re);
    end
  endtask

  task automatic test_single_write;
    addr[2] = 32'h40;
    d[2]    = D_DE;
    we[2]   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 32'h40 || mem_d !== D_DE) begin
      n_fail++;
      $display("[TB] FAIL write_issue: we=%b re=%b addr=%h d[31:0]=%h, required 1 0 00000040 deadbeef",
               mem_we, mem_re, mem_addr, mem_d[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_d !== D_DE) begin
        n_fail++;
        $display("[TB] FAIL write_hold: we=%b re=%b d[31:0]=%h, required 1 0 deadbeef", mem_we, mem_re, mem_d[31:0]);
      end
    end
    pulse_mem_rdy({64{8'h77}});
    n_checks++;
    if (rdy !== 4'b0100 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_done: rdy=%b we=%b re=%b, required 0100 0 0", rdy, mem_we, mem_re);
    end
    n_checks++;
    if (q2 !== Q_A5) begin
      n_fail++;
      $display("[TB] FAIL write_q_retained: q2[31:0]=%h, required a5a5a5a5", q2[31:0]);
    end
    we[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL write_pulse_len: rdy=%b, required 0000", rdy);
    end
  endtask

  task automatic test_round_robin;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    bit ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) addr[g] = 32'h1000 + 32'(g * 16);
    re = 4'hF;
    for (int t = 0; t < 5; t++) begin
      wait_mem_req(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL rr_timeout: step %0d no memory request, required one", t);
      end
      n_checks++;
      if (mem_addr !== addr[exp_g[t]]) begin
        n_fail++;
        $display("[TB] FAIL rr_order: step %0d addr=%h, required %h", t, mem_addr, addr[exp_g[t]]);
      end
      @(negedge clk);
      pulse_mem_rdy({16{32'(t)}});
      n_checks++;
      if (rdy !== (4'b0001 << exp_g[t])) begin
        n_fail++;
        $display("[TB] FAIL rr_rdy: step %0d rdy=%b, required %b", t, rdy, 4'b0001 << exp_g[t]);
      end
      re[exp_g[t]] = 1'b0;
      if (t == 0) begin
        @(negedge clk);
        re[0] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_rw_both;
    addr[1] = 32'h80;
    d[1]    = D_12;
    re[1]   = 1'b1;
    we[1]   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_d !== D_12 || mem_addr !== 32'h80) begin
      n_fail++;
      $display("[TB] FAIL rw_issue: we=%b re=%b addr=%h d[31:0]=%h, required 1 0 00000080 12345678",
               mem_we, mem_re, mem_addr, mem_d[31:0]);
    end
    @(negedge clk);
    pulse_mem_rdy({64{8'h99}});
    n_checks++;
    if (rdy !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL rw_rdy: rdy=%b, required 0010", rdy);
    end
    re[1] = 1'b0;
    we[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    addr[3] = 32'h300;
    re[3]   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h300) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_issue: re=%b addr=%h, required 1 00000300", mem_re, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_re, mem_we} !== 2'b00 || rdy !== 4'b0000 || mem_addr !== '0 || q0 !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_clear: re=%b we=%b rdy=%b addr=%h, required 0 0 0000 0", mem_re, mem_we, rdy, mem_addr);
    end
    rst   = 1'b0;
    re[3] = 1'b0;
    @(negedge clk);
    pulse_mem_rdy({64{8'hEE}});
    n_checks++;
    if (rdy !== 4'b0000 || {mem_re, mem_we} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_late_rdy: rdy=%b re=%b we=%b, required 0000 0 0", rdy, mem_re, mem_we);
    end
    addr[0] = 32'h200;
    re[0]   = 1'b1;
    re[3]   = 1'b1;
    wait_mem_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h200) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_priority: ok=%b addr=%h, required 1 00000200", ok, mem_addr);
    end
    pulse_mem_rdy(Q_X);
    re[0] = 1'b0;
    wait_mem_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h300) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_second: ok=%b addr=%h, required 1 00000300", ok, mem_addr);
    end
    pulse_mem_rdy(Q_Y);
    n_checks++;
    if (rdy !== 4'b1000 || q3 !== Q_Y) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_second_done: rdy=%b q3[31:0]=%h, required 1000 3c3c3c3c", rdy, q3[31:0]);
    end
    re[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spurious_rdy;
    @(negedge clk);
    pulse_mem_rdy({64{8'hFF}});
    @(negedge clk);
    n_checks++;
    if (rdy !== 4'b0000 || {mem_re, mem_we} !== 2'b00 || mem_addr !== 32'h300) begin
      n_fail++;
      $display("[TB] FAIL spurious_ctrl: rdy=%b re=%b we=%b addr=%h, required 0000 0 0 00000300",
               rdy, mem_re, mem_we, mem_addr);
    end
    n_checks++;
    if (q0 !== Q_Y || q1 !== Q_Y || q2 !== Q_Y || q3 !== Q_Y) begin
      n_fail++;
      $display("[TB] FAIL spurious_q: q0[31:0]=%h q3[31:0]=%h, required 3c3c3c3c", q0[31:0], q3[31:0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      d[i]    = '0;
    end
    @(negedge clk);
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_rw_both();
    test_reset_mid();
    test_spurious_rdy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
